// File: rtl/bus_pkg.sv
// Shared definitions for the bit-serial system bus: master FSM states, mode
// encoding and default frame widths used by both master and slave ports.
package bus_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 16;
  localparam int DEFAULT_DATA_WIDTH = 8;

  localparam logic MODE_READ  = 1'b0;
  localparam logic MODE_WRITE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR_TX,
    ST_DATA_TX,
    ST_RD_RX,
    ST_DONE
  } master_state_e;

  // Counter width able to hold max_val; never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/serial_master_port_if.sv
// Bit-serial bus wires between an initiator and a slave port.
interface serial_master_port_if;

  logic mode;
  logic wr_bus;
  logic master_valid;
  logic slave_ready;
  logic rd_bus;
  logic slave_valid;
  logic master_ready;

  modport master (
    output mode, wr_bus, master_valid, master_ready,
    input  slave_ready, rd_bus, slave_valid
  );

  modport slave (
    input  mode, wr_bus, master_valid, master_ready,
    output slave_ready, rd_bus, slave_valid
  );

endinterface

// File: rtl/bus_timeout_ctr.sv
// Saturating stall counter; expired flags the stalled cycle that reaches limit.
// A limit of zero never expires.
module bus_timeout_ctr #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic             expired
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W:0]   cnt_next;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign cnt_next = {1'b0, cnt} + (CNT_W+1)'(1);
  assign expired  = enable && (limit != '0) && (cnt_next >= {1'b0, limit});

endmodule

// File: rtl/serial_master_port.sv
// Initiator end of the bit-serial bus: shifts address then data out on wr_bus,
// collects read data from rd_bus, and returns a one-cycle response.
module serial_master_port
  import bus_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  serial_master_port_if.master  bus
);

  localparam int FRAME_W = ADDR_WIDTH + DATA_WIDTH;
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam int TO_W    = cnt_width(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

  master_state_e         state_q, state_d;
  logic [FRAME_W-1:0]    tx_shift;
  logic [CNT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;
  logic                  mode_q;
  logic                  mst_valid;
  logic                  mst_ready;
  logic                  stall;
  logic                  expired;
  logic                  to_clear;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    mst_valid = 1'b0;
    mst_ready = 1'b0;
    stall     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = ST_ADDR_TX;
      end
      ST_ADDR_TX: begin
        mst_valid = 1'b1;
        stall     = !bus.slave_ready;
        if (expired) begin
          state_d = ST_DONE;
        end else if (bus.slave_ready && (bit_cnt == CNT_W'(ADDR_WIDTH - 1))) begin
          state_d = ST_DATA_TX;
        end
      end
      ST_DATA_TX: begin
        mst_valid = 1'b1;
        stall     = !bus.slave_ready;
        if (expired) begin
          state_d = ST_DONE;
        end else if (bus.slave_ready && (bit_cnt == CNT_W'(FRAME_W - 1))) begin
          state_d = (mode_q == MODE_WRITE) ? ST_DONE : ST_RD_RX;
        end
      end
      ST_RD_RX: begin
        mst_ready = 1'b1;
        stall     = !bus.slave_valid;
        if (expired) begin
          state_d = ST_DONE;
        end else if (bus.slave_valid && (bit_cnt == CNT_W'(DATA_WIDTH - 1))) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        rsp_valid = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // bit_cnt is reused: frame position while sending, response bit index in RD_RX.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      tx_shift <= '0;
      bit_cnt  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      mode_q   <= MODE_READ;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            tx_shift <= {req_addr, (req_write ? req_wdata : DATA_WIDTH'(0))};
            mode_q   <= req_write;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            bit_cnt  <= '0;
          end
        end
        ST_ADDR_TX, ST_DATA_TX: begin
          if (expired) begin
            err_q <= 1'b1;
          end else if (bus.slave_ready) begin
            tx_shift <= tx_shift << 1;
            bit_cnt  <= (bit_cnt == CNT_W'(FRAME_W - 1)) ? '0 : bit_cnt + 1'b1;
          end
        end
        ST_RD_RX: begin
          if (expired) begin
            err_q <= 1'b1;
          end else if (bus.slave_valid) begin
            rdata_q <= {rdata_q[DATA_WIDTH-2:0], bus.rd_bus};
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Any non-stalled cycle or state change restarts the stall count.
  assign to_clear = !stall || (state_d != state_q);

  bus_timeout_ctr #(
    .CNT_W (TO_W)
  ) u_timeout (
    .clk     (clk),
    .rstn    (rstn),
    .clear   (to_clear),
    .enable  (stall),
    .limit   (TO_LIMIT),
    .expired (expired)
  );

  assign bus.master_valid = mst_valid;
  assign bus.master_ready = mst_ready;
  assign bus.wr_bus       = mst_valid & tx_shift[FRAME_W-1];
  assign bus.mode         = mode_q;
  assign rsp_rdata        = rdata_q;
  assign rsp_err          = err_q;

endmodule

// File: tb/tb_serial_master_port.sv
// Scoreboard bench for serial_master_port with a reactive slave model.
module tb_serial_master_port;

  typedef struct {
    logic [7:0] rdata;
    logic       err;
    logic       mode;
    int         xfers;
    int         stalls;
    int         mr_cyc;
    int         lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid, req_ready, req_write;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata, rsp_rdata;
  logic        rsp_valid, rsp_err;

  serial_master_port_if bus();

  serial_master_port #(
    .ADDR_WIDTH     (16),
    .DATA_WIDTH     (8),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic bitq[$];
  exp_t respq[$];

  int         sr_pol      = 0;
  int         stuck_after = 0;
  int         rd_gap      = 0;
  logic [7:0] rd_word     = 8'h00;

  int cyc = 0, acc_cyc = 0, acc_gap = 0, last_rsp_cyc = -100;
  int xfer_cnt = 0, stall_cnt = 0, mr_cnt = 0, rx_idx = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk_exp(input logic [7:0] rdata, input logic err, input logic mode,
                                  input int xfers, input int stalls, input int mr_cyc, input int lat);
    exp_t e;
    e.rdata = rdata; e.err = err; e.mode = mode;
    e.xfers = xfers; e.stalls = stalls; e.mr_cyc = mr_cyc; e.lat = lat;
    return e;
  endfunction

  // Slave model and monitor: drives slave inputs for the coming edge, then checks.
  initial begin
    logic prev_stall = 1'b0;
    logic prev_wr    = 1'b0;
    exp_t e;
    bus.slave_ready = 1'b1;
    bus.slave_valid = 1'b0;
    bus.rd_bus      = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rstn && req_valid && req_ready) begin
        acc_gap   = cyc - last_rsp_cyc;
        acc_cyc   = cyc;
        xfer_cnt  = 0;
        stall_cnt = 0;
        mr_cnt    = 0;
        rx_idx    = 0;
      end
      case (sr_pol)
        1:       bus.slave_ready = ~bus.slave_ready;
        2:       bus.slave_ready = (xfer_cnt < stuck_after);
        default: bus.slave_ready = 1'b1;
      endcase
      if (bus.master_ready) begin
        bus.slave_valid = (mr_cnt >= rd_gap) && (rx_idx < 8);
        bus.rd_bus      = bus.slave_valid ? rd_word[7-rx_idx] : 1'b0;
        mr_cnt++;
        if (bus.slave_valid) rx_idx++;
      end else begin
        bus.slave_valid = 1'b0;
        bus.rd_bus      = 1'b0;
      end
      if (rstn) begin
        if (bus.master_valid || bus.master_ready) begin
          check_eq("req_ready_busy", req_ready, 1'b0);
          check_eq("mv_mr_excl", bus.master_valid & bus.master_ready, 1'b0);
        end
        if (bus.master_valid) begin
          if (prev_stall) check_eq("wr_hold", bus.wr_bus, prev_wr);
          if (bus.slave_ready) begin
            if (bitq.size() == 0) check_eq("bit_extra", 1'b1, 1'b0);
            else check_eq("wr_bit", bus.wr_bus, bitq.pop_front());
            xfer_cnt++;
          end else begin
            stall_cnt++;
          end
          prev_stall = !bus.slave_ready;
          prev_wr    = bus.wr_bus;
        end else begin
          prev_stall = 1'b0;
        end
        if (rsp_valid) begin
          if (respq.size() == 0) begin
            check_eq("rsp_unexpected", 1'b1, 1'b0);
          end else begin
            e = respq.pop_front();
            check_eq("rsp_rdata", rsp_rdata, e.rdata);
            check_eq("rsp_err", rsp_err, e.err);
            check_eq("mode", bus.mode, e.mode);
            check_eq("req_ready_done", req_ready, 1'b0);
            if (e.xfers  >= 0) check_eq("xfers", xfer_cnt, e.xfers);
            if (e.stalls >= 0) check_eq("stalls", stall_cnt, e.stalls);
            if (e.mr_cyc >= 0) check_eq("mr_cycles", mr_cnt, e.mr_cyc);
            if (e.lat    >= 0) check_eq("latency", cyc - acc_cyc, e.lat);
          end
          last_rsp_cyc = cyc;
        end
      end
    end
  end

  // Called at posedge+2; returns at posedge+2 just after the accepting edge.
  task automatic send(input logic w, input logic [15:0] a, input logic [7:0] d,
                      input exp_t e, input logic push_rsp, input logic hold);
    logic done = 1'b0;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    for (int i = 0; i < 200 && !done; i++) begin
      if (req_ready) begin
        for (int b = 15; b >= 0; b--) bitq.push_back(a[b]);
        for (int b = 7; b >= 0; b--) bitq.push_back(w ? d[b] : 1'b0);
        if (push_rsp) respq.push_back(e);
        done = 1'b1;
      end
      @(posedge clk); #2;
    end
    if (!done) check_eq("accept_timeout", 1'b0, 1'b1);
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 400 && respq.size() != 0; i++) begin
      @(posedge clk); #2;
    end
    check_eq("rsp_pending", respq.size(), 0);
    respq.delete();
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_req_ready"}, req_ready, 1'b1);
    check_eq({tag, "_rsp_valid"}, rsp_valid, 1'b0);
    check_eq({tag, "_rsp_rdata"}, rsp_rdata, 8'h00);
    check_eq({tag, "_rsp_err"}, rsp_err, 1'b0);
    check_eq({tag, "_mode"}, bus.mode, 1'b0);
    check_eq({tag, "_wr_bus"}, bus.wr_bus, 1'b0);
    check_eq({tag, "_master_valid"}, bus.master_valid, 1'b0);
    check_eq({tag, "_master_ready"}, bus.master_ready, 1'b0);
  endtask

  initial begin
    rstn = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (2) @(posedge clk);
    #2;
    check_idle_outputs("reset");
    rstn = 1'b1;
    @(posedge clk); #2;

    // Plain write, slave always ready.
    sr_pol = 0;
    send(1'b1, 16'h0025, 8'hA5, mk_exp(8'h00, 1'b0, 1'b1, 24, 0, 0, 25), 1'b1, 1'b0);
    wait_done();

    // Same write with the slave ready every other cycle.
    sr_pol = 1;
    send(1'b1, 16'h0025, 8'hA5, mk_exp(8'h00, 1'b0, 1'b1, 24, -1, 0, -1), 1'b1, 1'b0);
    wait_done();
    sr_pol = 0;

    // Read with a 3-cycle response gap.
    rd_word = 8'h3C; rd_gap = 3;
    send(1'b0, 16'h0025, 8'hFF, mk_exp(8'h3C, 1'b0, 1'b0, 24, 0, 11, 36), 1'b1, 1'b0);
    wait_done();
    repeat (3) @(posedge clk);
    #2;
    check_eq("rdata_hold", rsp_rdata, 8'h3C);
    check_eq("mode_hold", bus.mode, 1'b0);

    // Slave stops accepting after 5 address bits.
    sr_pol = 2; stuck_after = 5;
    send(1'b1, 16'h0025, 8'hA5, mk_exp(8'h00, 1'b1, 1'b1, 5, 8, 0, 14), 1'b1, 1'b0);
    wait_done();
    bitq.delete();
    sr_pol = 0;
    @(posedge clk); #2;

    // Reset in the middle of the data phase, then a clean write.
    send(1'b1, 16'h0F0F, 8'h33, mk_exp(8'h00, 1'b0, 1'b1, -1, -1, -1, -1), 1'b0, 1'b0);
    for (int i = 0; i < 100 && xfer_cnt < 18; i++) begin
      @(posedge clk); #2;
    end
    check_eq("reached_data_tx", xfer_cnt >= 18, 1'b1);
    rstn = 1'b0;
    @(posedge clk); #2;
    check_idle_outputs("midreset");
    rstn = 1'b1;
    bitq.delete();
    repeat (30) @(posedge clk);
    #2;
    send(1'b1, 16'h1234, 8'h5A, mk_exp(8'h00, 1'b0, 1'b1, 24, 0, 0, 25), 1'b1, 1'b0);
    wait_done();

    // Back-to-back: req_valid stays high across two requests.
    rd_word = 8'h96; rd_gap = 0;
    send(1'b1, 16'h0100, 8'h11, mk_exp(8'h00, 1'b0, 1'b1, 24, 0, 0, 25), 1'b1, 1'b1);
    send(1'b0, 16'h0200, 8'h00, mk_exp(8'h96, 1'b0, 1'b0, 24, 0, 8, 33), 1'b1, 1'b0);
    check_eq("b2b_accept_gap", acc_gap, 1);
    wait_done();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
